// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for an external 8:1 mux: latches a word, walks the select lines across all
// eight inputs and streams the selected bit out over a valid/ready handshake.
module mux_scan_sequencer #(
    parameter int MSB_FIRST = 0,
    parameter int GAP       = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    output logic       load_ready,
    output logic [7:0] b,
    output logic [2:0] sel,
    input  logic       mux_o,
    output logic       bit_valid,
    input  logic       bit_ready,
    output logic       bit_out,
    output logic [2:0] bit_idx,
    output logic       frame_done
);

    localparam logic [2:0] START_IDX = (MSB_FIRST != 0) ? 3'd7 : 3'd0;
    localparam logic [2:0] END_IDX   = (MSB_FIRST != 0) ? 3'd0 : 3'd7;
    localparam logic [3:0] GAP_LAST  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_GAP
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] word;
    logic [7:0] word_nxt;
    logic [2:0] idx;
    logic [2:0] idx_nxt;
    logic [2:0] idx_step;
    logic       last_bit;
    logic [3:0] gap_cnt;
    logic [3:0] gap_cnt_nxt;
    // Holds load_ready low for the first cycle after reset release.
    logic       armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            word    <= 8'd0;
            idx     <= START_IDX;
            gap_cnt <= 4'd0;
            armed   <= 1'b0;
        end else begin
            state   <= state_nxt;
            word    <= word_nxt;
            idx     <= idx_nxt;
            gap_cnt <= gap_cnt_nxt;
            armed   <= 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        word_nxt    = word;
        idx_nxt     = idx;
        gap_cnt_nxt = gap_cnt;
        load_ready  = 1'b0;
        bit_valid   = 1'b0;
        frame_done  = 1'b0;
        idx_step    = (MSB_FIRST != 0) ? (idx - 3'd1) : (idx + 3'd1);
        last_bit    = (idx == END_IDX);

        case (state)
            S_IDLE: begin
                load_ready = armed;
                if (load_valid && armed) begin
                    word_nxt  = load_data;
                    idx_nxt   = START_IDX;
                    state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                bit_valid = 1'b1;
                if (bit_ready) begin
                    // The last index never steps, so the select cannot wrap inside a frame.
                    if (last_bit) begin
                        frame_done = 1'b1;
                        state_nxt  = (GAP > 0) ? S_GAP : S_IDLE;
                    end else begin
                        idx_nxt = idx_step;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt_nxt = 4'd0;
                    state_nxt   = S_IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign b       = word;
    assign sel     = idx;
    assign bit_idx = idx;
    // Unregistered: the external mux path lands directly on this output.
    assign bit_out = mux_o;

endmodule
